// File: rtl/vram_arb_pkg.sv
// Shared types and latency constants for the VRAM arbiter.
package vram_arb_pkg;

  typedef enum logic [0:0] {
    DISPLAY = 1'b0,
    ARB     = 1'b1
  } arb_state_e;

  localparam int VRAM_RD_LAT = 1;
  localparam int ARB_LAT     = 2;
  localparam int STARVE_W    = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first set req_i at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] win_o
);

  logic             found;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt_o = '0;
    win_o = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
      idx = sum[IDX_W-1:0];
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        win_o      = idx;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM sharing between the renderer (visible lines) and round-robin game logic (vblank).
// Define VRAM_ARB_STATS_EN to add the saturating starve_frames counter output.
//
// state   | meaning
// DISPLAY | renderer reads forwarded, no grants; waits for blank rising edge
// ARB     | requesters served round-robin while blank is high
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    blank,
  input  logic                    pix_req,
  input  logic [ADDR_W-1:0]       pix_addr,
  output logic                    pix_valid,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic [N_REQ-1:0]        we,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        rvalid,
  output logic                    frame_start,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_we,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [STARVE_W-1:0]     starve_frames
`endif
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e       state_q, state_d;
  logic             blank_q, blank_rise, blank_fall;
  logic [IDX_W-1:0] ptr_q, ptr_d, rr_win;
  logic [IDX_W:0]   ptr_inc;
  logic [N_REQ-1:0] rr_gnt;

  logic              acc, acc_we, acc_pix;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [N_REQ-1:0]  acc_rd;
  logic              frame_start_d;

  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              rd_pix_q, pix_valid_q, frame_start_q;
  logic [N_REQ-1:0]  rd_req_q, rvalid_q;

  // mem_rdata goes straight to the clients; this block only tags who owns it.
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;

  assign blank_rise = blank & ~blank_q;
  assign blank_fall = ~blank & blank_q;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (rr_gnt),
    .win_o (rr_win)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gnt           = '0;
    acc           = 1'b0;
    acc_we        = 1'b0;
    acc_pix       = 1'b0;
    acc_addr      = pix_addr;
    acc_wdata     = '0;
    acc_rd        = '0;
    frame_start_d = 1'b0;
    ptr_inc       = {1'b0, rr_win} + (IDX_W+1)'(1);
    if (ptr_inc == (IDX_W+1)'(N_REQ)) ptr_inc = '0;

    case (state_q)
      DISPLAY: begin
        if (pix_req) begin
          acc     = 1'b1;
          acc_pix = 1'b1;
        end
        if (blank_rise) begin
          frame_start_d = 1'b1;
          state_d       = ARB;
        end
      end
      ARB: begin
        if (blank_fall) begin
          state_d = DISPLAY;
        end else if (blank && (|req)) begin
          gnt   = rr_gnt;
          acc   = 1'b1;
          ptr_d = ptr_inc[IDX_W-1:0];
          for (int i = 0; i < N_REQ; i++) begin
            if (rr_gnt[i]) begin
              acc_addr  = addr[i*ADDR_W +: ADDR_W];
              acc_we    = we[i];
              acc_wdata = wdata[i*DATA_W +: DATA_W];
            end
          end
          acc_rd = acc_we ? '0 : rr_gnt;
        end
      end
      default: state_d = DISPLAY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= DISPLAY;
      blank_q       <= 1'b1;
      ptr_q         <= '0;
      mem_addr_q    <= '0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= '0;
      rd_pix_q      <= 1'b0;
      rd_req_q      <= '0;
      pix_valid_q   <= 1'b0;
      rvalid_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      blank_q       <= blank;
      ptr_q         <= ptr_d;
      mem_we_q      <= acc & acc_we;
      if (acc) begin
        mem_addr_q  <= acc_addr;
        mem_wdata_q <= acc_wdata;
      end
      rd_pix_q      <= acc_pix;
      rd_req_q      <= acc_rd;
      pix_valid_q   <= rd_pix_q;
      rvalid_q      <= rd_req_q;
      frame_start_q <= frame_start_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign pix_valid   = pix_valid_q;
  assign rvalid      = rvalid_q;
  assign frame_start = frame_start_q;

`ifdef VRAM_ARB_STATS_EN
  logic [STARVE_W-1:0] starve_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else if (blank_fall && (|req) && (starve_q != '1)) begin
      starve_q <= starve_q + STARVE_W'(1);
    end
  end

  assign starve_frames = starve_q;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a response scoreboard and a behavioural RAM.
// Honours VRAM_ARB_STATS_EN to also check starve_frames.
module tb_vram_arbiter;
  import vram_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 13;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            blank = 1'b0;
  logic            pix_req = 1'b0;
  logic [AW-1:0]   pix_addr = '0;
  logic            pix_valid;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N-1:0]    we = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic            frame_start;
  logic [AW-1:0]   mem_addr;
  logic            mem_we;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0]     starve_frames;
`endif

  vram_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .blank       (blank),
    .pix_req     (pix_req),
    .pix_addr    (pix_addr),
    .pix_valid   (pix_valid),
    .req         (req),
    .addr        (addr),
    .we          (we),
    .wdata       (wdata),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .frame_start (frame_start),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
`ifdef VRAM_ARB_STATS_EN
    ,
    .starve_frames (starve_frames)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 8'hE7;
  endfunction

  // Synchronous single-port RAM, one-cycle read latency.
  logic [DW-1:0] ram     [0:(1<<AW)-1];
  bit            written [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    mem_rdata <= written[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
  end

  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    int            due;
    logic [N-1:0]  rv;
    logic          pv;
    logic [DW-1:0] data;
  } rsp_t;

  cmd_t cq[$];
  rsp_t rq[$];

  int vec  = 0;
  int errs = 0;
  int cyc  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    addr[i*AW +: AW] = a;
    we[i]            = w;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic post_check(input bit exp_fs);
    cmd_t c;
    rsp_t r;
    if (cq.size() > 0 && cq[0].due == cyc) begin
      c = cq.pop_front();
      chk("mem_addr", 32'(mem_addr), 32'(c.addr));
      chk("mem_we", 32'(mem_we), 32'(c.we));
      if (c.we) chk("mem_wdata", 32'(mem_wdata), 32'(c.wdata));
    end else begin
      chk("mem_we_idle", 32'(mem_we), 32'(0));
    end
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      chk("rvalid", 32'(rvalid), 32'(r.rv));
      chk("pix_valid", 32'(pix_valid), 32'(r.pv));
      chk("mem_rdata", 32'(mem_rdata), 32'(r.data));
    end else begin
      chk("rvalid_idle", 32'(rvalid), 32'(0));
      chk("pix_valid_idle", 32'(pix_valid), 32'(0));
    end
    chk("frame_start", 32'(frame_start), 32'(exp_fs));
  endtask

  // Inputs for the current cycle are already driven; check grants, book
  // expected accesses, cross the clock edge and check what is due.
  task automatic cycle(input logic [N-1:0] exp_gnt, input bit exp_pix, input bit exp_fs);
    cmd_t          c;
    rsp_t          r;
    logic [N-1:0]  oh;
    #1;
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    if (exp_pix) begin
      c.due = cyc + ARB_LAT - VRAM_RD_LAT; c.addr = pix_addr; c.we = 1'b0; c.wdata = '0;
      cq.push_back(c);
      r.due = cyc + ARB_LAT; r.rv = '0; r.pv = 1'b1; r.data = mem_val(pix_addr);
      rq.push_back(r);
    end
    for (int i = 0; i < N; i++) begin
      if (exp_gnt[i]) begin
        c.due = cyc + ARB_LAT - VRAM_RD_LAT;
        c.addr = addr[i*AW +: AW]; c.we = we[i]; c.wdata = wdata[i*DW +: DW];
        cq.push_back(c);
        if (we[i]) begin
          ref_mem[c.addr] = c.wdata;
        end else begin
          oh = '0; oh[i] = 1'b1;
          r.due = cyc + ARB_LAT; r.rv = oh; r.pv = 1'b0; r.data = mem_val(c.addr);
          rq.push_back(r);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    post_check(exp_fs);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_mem_addr", 32'(mem_addr), 32'(0));
    chk("rst_mem_we", 32'(mem_we), 32'(0));
    chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
    chk("rst_rvalid", 32'(rvalid), 32'(0));
    chk("rst_pix_valid", 32'(pix_valid), 32'(0));
    chk("rst_frame_start", 32'(frame_start), 32'(0));
`ifdef VRAM_ARB_STATS_EN
    chk("rst_starve", 32'(starve_frames), 32'(0));
`endif
    reset = 1'b1;
    cycle('0, 1'b0, 1'b0);

    // Renderer path, requesters ignored during display
    for (int i = 0; i < N; i++) set_req(i, AW'(16 + i), 1'b0, '0);
    req = 4'b1111;
    pix_req = 1'b1; pix_addr = 13'h0100;
    cycle('0, 1'b1, 1'b0);
    pix_addr = 13'h01FF;
    cycle('0, 1'b1, 1'b0);
    pix_req = 1'b0; req = '0;
    cycle('0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);

    // Frame start then full rotation, renderer ignored in ARB
    blank = 1'b1;
    cycle('0, 1'b0, 1'b1);
    pix_req = 1'b1; req = 4'b1111;
    cycle(4'b0001, 1'b0, 1'b0);
    cycle(4'b0010, 1'b0, 1'b0);
    cycle(4'b0100, 1'b0, 1'b0);
    cycle(4'b1000, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0);

    // Single requester repeats; pointer continues from last winner
    req = 4'b0100;
    cycle(4'b0100, 1'b0, 1'b0);
    cycle(4'b0100, 1'b0, 1'b0);
    cycle(4'b0100, 1'b0, 1'b0);
    req = 4'b1001;
    cycle(4'b1000, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0);

    // Read, write, read back
    req = 4'b0010; set_req(1, 13'h0042, 1'b0, '0);
    cycle(4'b0010, 1'b0, 1'b0);
    req = '0;
    cycle('0, 1'b0, 1'b0);
    req = 4'b0010; set_req(1, 13'h0042, 1'b1, 8'h5A);
    cycle(4'b0010, 1'b0, 1'b0);
    req = '0;
    cycle('0, 1'b0, 1'b0);
    req = 4'b0010; set_req(1, 13'h0042, 1'b0, '0);
    cycle(4'b0010, 1'b0, 1'b0);
    req = '0;
    cycle('0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);

    // Read in flight across the blank fall; pending request blocked
    req = 4'b0001; set_req(0, 13'h0300, 1'b0, '0);
    cycle(4'b0001, 1'b0, 1'b0);
`ifdef VRAM_ARB_STATS_EN
    chk("starve_pre", 32'(starve_frames), 32'(0));
`endif
    blank = 1'b0; pix_addr = 13'h0200;
    cycle('0, 1'b0, 1'b0);
`ifdef VRAM_ARB_STATS_EN
    chk("starve_post", 32'(starve_frames), 32'(1));
`endif
    cycle('0, 1'b1, 1'b0);
    pix_addr = 13'h0201;
    cycle('0, 1'b1, 1'b0);
    pix_req = 1'b0; req = '0;
    cycle('0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);

    // Async reset between grant and rvalid
    blank = 1'b1;
    cycle('0, 1'b0, 1'b1);
    req = 4'b0100; set_req(2, 13'h0055, 1'b0, '0);
    cycle(4'b0100, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'(0));
    chk("arst_mem_addr", 32'(mem_addr), 32'(0));
    chk("arst_mem_we", 32'(mem_we), 32'(0));
    chk("arst_rvalid", 32'(rvalid), 32'(0));
    chk("arst_pix_valid", 32'(pix_valid), 32'(0));
    chk("arst_frame_start", 32'(frame_start), 32'(0));
`ifdef VRAM_ARB_STATS_EN
    chk("arst_starve", 32'(starve_frames), 32'(0));
`endif
    cq.delete();
    rq.delete();
    cycle('0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    reset = 1'b1;
    cycle('0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);
    blank = 1'b0;
    cycle('0, 1'b0, 1'b0);
`ifdef VRAM_ARB_STATS_EN
    chk("starve_after_rst", 32'(starve_frames), 32'(1));
`endif
    blank = 1'b1;
    cycle('0, 1'b0, 1'b1);
    req = 4'b1010; set_req(1, 13'h0077, 1'b0, '0); set_req(3, 13'h0078, 1'b0, '0);
    cycle(4'b0010, 1'b0, 1'b0);
    req = 4'b1000;
    cycle(4'b1000, 1'b0, 1'b0);
    req = '0;
    cycle('0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b0);

    chk("sb_drained", 32'(cq.size() + rq.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port video RAM between the pixel renderer and up to `N_REQ` game-logic requesters (player, alien grid, missiles, score). The renderer owns the RAM while the screen is drawn. During vertical blanking the requesters get round-robin access, one access per cycle. The block sits between the VGA timing generator's blanking output and the synchronous VRAM, and emits a `frame_start` pulse that game logic uses to schedule its per-frame updates.

## Interface
- `N_REQ`, 4: number of game-logic requesters, range 2..8.
- `ADDR_W`, 13: VRAM address width.
- `DATA_W`, 8: VRAM data width.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `blank` in 1: vertical blanking level from the timing generator; 1 means no visible lines.
- `pix_req` in 1: renderer read request for this cycle.
- `pix_addr` in `ADDR_W`: renderer read address.
- `pix_valid` out 1: `mem_rdata` belongs to the renderer.
- `req` in `N_REQ`: per-requester access request, held until granted.
- `addr` in `N_REQ*ADDR_W`: packed per-requester addresses; requester i uses slice i.
- `we` in `N_REQ`: per-requester write enable.
- `wdata` in `N_REQ*DATA_W`: packed per-requester write data.
- `gnt` out `N_REQ`: one-hot grant; the access is accepted in the cycle `gnt[i]` is high.
- `rvalid` out `N_REQ`: one-hot; `mem_rdata` holds the read result for requester i.
- `frame_start` out 1: one-cycle pulse at the start of vertical blanking.
- `mem_addr` out `ADDR_W`, `mem_we` out 1, `mem_wdata` out `DATA_W`: registered RAM command.
- `mem_rdata` in `DATA_W`: RAM read data, valid one cycle after the command.

## Operation
- States: `DISPLAY`, `ARB`.
- Reset state is `DISPLAY`. All outputs reset to 0, the round-robin pointer to 0, and `blank_q` to 1.
- `blank_q` is `blank` registered. Rising edge = `blank & ~blank_q`; falling edge = `~blank & blank_q`.
- `DISPLAY` state:
  - `pix_req` is forwarded as a read command.
  - `gnt` stays 0.
  - On a rising edge of `blank`: `frame_start` = 1 for one cycle, then go to `ARB`.
- `ARB` state:
  - `pix_req` is ignored and `pix_valid` stays 0.
  - Grant rule: `gnt` is combinational and requires `blank` = 1 in the same cycle.
  - The winner is the first `req[j]` set, searching from the pointer upward and wrapping at `N_REQ`-1 back to 0.
  - After a grant the pointer becomes winner+1 mod `N_REQ`.
  - A requester that holds `req` gets consecutive grants only while no other requester is asserting `req`.
  - A falling edge of `blank` (`blank` = 0) returns the block to `DISPLAY`. No grant is issued in that cycle, even if `req` is set.
- A read already in flight at the ARB→DISPLAY switch still returns with its own `rvalid[i]`. The RAM is pipelined, so it does not collide with the first renderer access.
- Writes produce no `rvalid`.
- If reset is asserted mid-frame, any in-flight read is dropped with no `rvalid`. After reset release the block stays in `DISPLAY` until the next rising edge of `blank`.

## Timing
- Accepted access, renderer or requester, in cycle t:
  - `mem_addr`/`mem_we`/`mem_wdata` are driven in cycle t+1.
  - `rvalid`/`pix_valid` and `mem_rdata` are valid in cycle t+2.
  - Latency is 2 cycles for both paths.
- Throughput: one access per cycle.
- `mem_we` = 0 whenever no access was accepted in the previous cycle.
- `frame_start` is high in the cycle after `blank` is first sampled high.
- There is no `frame_start` if `blank` is already high at reset release, because `blank_q` resets to 1.

## Configuration
- `VRAM_ARB_STATS_EN` defined: adds output `starve_frames` (16 bits, reset 0, saturating).
  - It increments on each falling edge of `blank` at which any `req` bit is still set.
  - Game logic uses it to detect that its per-frame work overran the blanking interval.
- Not defined: the port and the counter are absent; behaviour is otherwise identical.

## Structure
- Shared package `vram_arb_pkg` holds:
  - the state enum (`DISPLAY`, `ARB`);
  - `VRAM_RD_LAT` = 1 (the RAM read latency);
  - `ARB_LAT` = 2 (the access latency through this block).
- Sub-module `rr_arbiter`: combinational round-robin priority select. Inputs are `req` and the pointer; outputs are a one-hot `gnt` and the winner index. The pointer register stays in `vram_arbiter`.

## Test plan
- **Renderer path:** `blank`=0, `pix_req`=1, `pix_addr`=0x0100 at cycle t → `mem_addr`=0x0100 at t+1 → `pix_valid`=1 at t+2; `gnt` stays 0 throughout.
- **Frame start:** `blank` goes 0→1 → `frame_start` pulses for exactly 1 cycle. With `req`=4'b1111 held, `gnt` = 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
- **Single requester and pointer:** only `req[2]`=1 → `gnt[2]` every cycle. Then `req`=4'b1001 → `gnt[3]` first, then `gnt[0]`.
- **Read then write:** requester 1 reads 0x0042 (RAM holds 0xA5) → `rvalid[1]`=1 with `mem_rdata`=0xA5 two cycles after the grant. Requester 1 then writes 0x5A to 0x0042 → `mem_we`=1 at grant+1 and no `rvalid`.
- **Blank falls with a pending request:** `blank` 1→0 while `req[0]`=1 → no grant that cycle, `pix_valid` resumes. With `VRAM_ARB_STATS_EN`, `starve_frames` goes 0→1.
- **Async reset mid-access:** `reset` driven low between grant and `rvalid` → all outputs 0 immediately and no `rvalid`. After release with `blank`=1, no `frame_start` until `blank` has gone 0 and then 1 again.
